// File: rtl/irq_pend_pkg.sv
// Shared constants, state encoding and helpers for irq_pend_ctrl.
// Optional build macro: ROUND_ROBIN_EN.
package irq_pend_pkg;

  localparam int N_SRC = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'b00;
  localparam state_t REQ      = 2'b01;
  localparam state_t WAIT_CLR = 2'b10;

  function automatic logic [N_SRC-1:0] rotl4(
    input logic [N_SRC-1:0] v,
    input logic [ID_W-1:0]  n
  );
    logic [2*N_SRC-1:0] d;
    d = {v, v} << n;
    return d[2*N_SRC-1 -: N_SRC];
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest index wins.
// Purely combinational; rotation for fairness is applied by the caller.
module irq_prio_enc
  import irq_pend_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             found
);

  assign found = |req;

  always_comb begin
    id = '0;
    unique casez (req)
      4'b???1: id = 2'd0;
      4'b??10: id = 2'd1;
      4'b?100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = '0;
    endcase
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Edge-latched interrupt pending register with mask and ack handshake.
// Define ROUND_ROBIN_EN for rotating priority after each ack.
module irq_pend_ctrl
  import irq_pend_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] mask,
  input  logic             ack,
  output logic [N_SRC-1:0] irq_pend,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(ACK_TIMEOUT - 1);

  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] req;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  id_d;
  logic [ID_W-1:0]  enc_id;
  logic [ID_W-1:0]  win_id;
  logic             found;
  logic             acc;
  logic             expire;
  logic             tmo_q;
  logic             tmo_d;

  assign rise     = irq_src & ~irq_q;
  assign irq_pend = pending & ~mask;
  assign acc      = (state_q == REQ) & ack;
  assign expire   = (state_q == REQ) & ~ack
                  & (cnt_q == TMO_LAST);
  assign clr      = acc ? (N_SRC'(1) << id_q)
                        : '0;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] start;

  assign start  = last_q + ID_W'(1);
  // Rotate so the source after last_id lands on bit 0.
  assign req    = rotl4(irq_pend, -start);
  assign win_id = enc_id + start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= ID_W'(3);
    end else if (acc) begin
      last_q <= id_q;
    end
  end
`else
  assign req    = irq_pend;
  assign win_id = enc_id;
`endif

  irq_prio_enc u_enc (
    .req   (req),
    .id    (enc_id),
    .found (found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (found) state_d = REQ;
      end
      REQ: begin
        if (ack) begin
          state_d = WAIT_CLR;
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
        end
      end
      WAIT_CLR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    id_d  = id_q;
    tmo_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d  = win_id;
          cnt_d = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        tmo_d = expire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      irq_q   <= irq_src;
      pending <= rise | (pending & ~clr);
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      tmo_q   <= tmo_d;
    end
  end

  assign irq_valid = (state_q == REQ);
  assign irq_id    = id_q;
  assign timeout   = tmo_q;

endmodule

// File: doc/irq_pend_ctrl.md
Name: irq_pend_ctrl

Overview:
Latches four interrupt sources into a pending register and applies a mask. Drives irq_pend[3:0] directly into the delayed 4-input OR stage, which forms the CPU interrupt wire. In parallel, it arbitrates one pending source at a time and presents its ID to the CPU under a valid/ack handshake, with an ack timeout.

Parameters:
N_SRC, 4, number of interrupt sources; fixed at 4 to match the 4-input OR stage.
ID_W, 2, width of irq_id.
ACK_TIMEOUT, 15, cycles in REQ without ack before timeout; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
irq_src  input  4  level interrupt sources, synchronous to clk.
mask  input  4  1 = source masked (blocked from irq_pend and arbitration).
ack  input  1  CPU acknowledge of the presented irq_id.
irq_pend  output  4  pending & ~mask; feeds the 4-input OR stage.
irq_valid  output  1  irq_id is valid and awaiting ack.
irq_id  output  2  index of the granted source.
timeout  output  1  one-cycle pulse when an ack timeout occurs.

Behaviour:
- Reset (asynchronous, active-high) clears all state: irq_q=0, pending=0, state=IDLE, counter=0, irq_valid=0, irq_id=0, timeout=0, irq_pend=0.
- Edge detect:
  - irq_q registers irq_src every cycle.
  - rise = irq_src & ~irq_q.
  - Only rising edges set pending; a held-high level sets pending once.
- Pending update per bit, each clk:
  - pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - clr[i] = ack accepted in REQ with irq_id==i.
  - If set and clear coincide, set wins.
- irq_pend = pending & ~mask, combinational from registers. Masked bits stay latched in pending and reappear when unmasked.
- Latency:
  - irq_src goes high before edge k → irq_pend[i]=1 after edge k.
  - irq_valid=1 after edge k+1 if the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT_CLR.
  - IDLE: if (pending & ~mask) != 0, then irq_id <= encoded winner, irq_valid <= 1, counter <= 0, go to REQ. Otherwise stay.
  - REQ:
    - irq_id and irq_valid hold stable; counter increments.
    - ack=1 → clear pending[irq_id], irq_valid <= 0, go to WAIT_CLR.
    - Otherwise, when counter reaches ACK_TIMEOUT-1 → timeout pulses for 1 cycle, irq_valid <= 0, pending kept, go to IDLE.
    - If ack and timeout coincide, ack wins with no timeout pulse.
  - WAIT_CLR: irq_valid=0 for exactly one cycle, then go to IDLE. This guarantees a one-cycle gap between grants.
- ack in IDLE or WAIT_CLR is ignored and has no effect.
- Masking irq_id's source while in REQ does not revoke the grant; it completes by ack or timeout.
- Default priority is fixed, with lowest index highest (0 > 1 > 2 > 3).
- A reset asserted mid-REQ drops irq_valid immediately (asynchronous) and discards all pending.

Optional Feature:
ROUND_ROBIN_EN:
- Defined: a 2-bit last_id register (reset 3) is updated on each ack. Priority rotates, starting at last_id+1 and wrapping modulo 4. Timeout does not update last_id.
- Undefined: fixed priority as above; no last_id register.

Decomposition:
- Package irq_pend_pkg holds:
  - N_SRC=4 and ID_W=2.
  - State encoding localparams IDLE=2'b00, REQ=2'b01, WAIT_CLR=2'b10.
  - Function rotl4 for round-robin masking.
- One sub-module, irq_prio_enc: a 4-bit request input gives a 2-bit id plus a found flag, fixed lowest-index priority, purely combinational. Round-robin rotates the request vector around it.

Test Plan:
1. Reset mid-REQ: with irq_valid=1, assert reset → irq_valid, irq_pend, irq_id and timeout all 0 immediately; after release, no re-grant without a new edge.
2. Single source: irq_src=4'b0100, mask=0 → irq_pend=4'b0100 after edge k; irq_valid=1 with irq_id=2 after k+1. Pulse ack → irq_pend=0, irq_valid=0, and the WAIT_CLR gap is observed.
3. Simultaneous sources 4'b1010, fixed priority → grant id=1; ack → one gap cycle → grant id=3; ack → irq_pend=0. With ROUND_ROBIN_EN, last_id=1 and sources 4'b0011 → grant id=0 before id=1.
4. Mask: source 0 rises with mask=4'b0001 → pending set internally, irq_pend=0, irq_valid=0. Clear the mask → irq_pend=4'b0001 the same cycle, grant id=0 the next cycle.
5. Timeout: ACK_TIMEOUT=4, source 3 granted, no ack → timeout pulses high for exactly 1 cycle after the 4th REQ cycle. The FSM then returns to IDLE, irq_pend[3] stays 1, and id=3 is re-granted.
6. Set/clear collision: ack for id=0 in the same cycle source 0 shows a new rising edge → pending[0] stays 1, and id=0 is re-granted after WAIT_CLR.
